// File: rtl/uart_cmd_responder.sv
// Two-byte {CMD, ARG} request parser and {CODE, DATA} responder sitting between
// the UART rx/tx pair and the sensor/LED logic.
module uart_cmd_responder #(
  parameter int NUM_CH       = 4,
  parameter int TIMEOUT_CLKS = 50000000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  input  logic [8*NUM_CH-1:0]   i_Ch_Data,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  output logic [2:0]            o_Led,
  output logic                  o_Busy,
  output logic [7:0]            o_Drop_Count
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ARG,
    EXEC,
    SEND_CODE,
    WAIT_CODE,
    SEND_DATA,
    WAIT_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       arg_q, arg_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [2:0]       led_q, led_d;
  logic [7:0]       drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] ch_sel;
  logic [7:0] exec_code;
  logic [7:0] exec_data;
  logic       drop_inc;

  // Transmitter busy is not needed: i_Tx_Done alone paces the response.
  logic unused_tx_active;
  assign unused_tx_active = i_Tx_Active;

  always_comb begin
    ch_sel = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (arg_q == 8'(k)) ch_sel = i_Ch_Data[8*k +: 8];
    end
  end

  always_comb begin
    exec_code = 8'hFF;
    exec_data = cmd_q;
    case (cmd_q)
      8'h01: begin
        if ({1'b0, arg_q} < 9'(NUM_CH)) begin
          exec_code = 8'h01;
          exec_data = ch_sel;
        end else begin
          exec_code = 8'hFE;
          exec_data = arg_q;
        end
      end
      8'h02: begin
        exec_code = 8'h02;
        exec_data = {5'b0, arg_q[2:0]};
      end
      8'h03: begin
        exec_code = 8'h03;
        exec_data = drop_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    data_d    = data_q;
    tx_byte_d = tx_byte_q;
    led_d     = led_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    drop_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          cnt_d   = '0;
          state_d = WAIT_ARG;
        end
      end
      WAIT_ARG: begin
        // A byte in the final timeout cycle still wins over the timeout.
        if (i_Rx_DV) begin
          arg_d   = i_Rx_Byte;
          state_d = EXEC;
        end else if (cnt_q == CNT_LAST) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXEC: begin
        tx_byte_d = exec_code;
        data_d    = exec_data;
        if (cmd_q == 8'h02) led_d = arg_q[2:0];
        state_d   = SEND_CODE;
      end
      SEND_CODE: state_d = WAIT_CODE;
      WAIT_CODE: begin
        if (i_Tx_Done) begin
          tx_byte_d = data_q;
          state_d   = SEND_DATA;
        end
      end
      SEND_DATA: state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (i_Tx_Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_Rx_DV && state_q != IDLE && state_q != WAIT_ARG) drop_inc = 1'b1;
    if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      arg_q     <= '0;
      data_q    <= '0;
      tx_byte_q <= '0;
      led_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      data_q    <= data_d;
      tx_byte_q <= tx_byte_d;
      led_q     <= led_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_Tx_DV      = (state_q == SEND_CODE) || (state_q == SEND_DATA);
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Led        = led_q;
  assign o_Busy       = (state_q != IDLE);
  assign o_Drop_Count = drop_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: transaction-level response model,
// byte scoreboard on every o_Tx_DV, and a simple transmitter responder.
module tb_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [31:0] ch_data = 32'h335A2211;
  logic        tx_active = 1'b0;
  logic        tx_done_m = 1'b0;
  logic        done_force = 1'b0;
  logic        tx_done;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [2:0]  led;
  logic        busy;
  logic [7:0]  drop_cnt;

  int          errors = 0;
  int          checks = 0;
  int          dv_count = 0;
  int          tx_dly = 4;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_drop = '0;
  logic [2:0]  exp_led = '0;
  logic        prev_dv = 1'b0;
  logic        holding = 1'b0;
  logic [7:0]  hold_byte = '0;

  assign tx_done = tx_done_m | done_force;

  uart_cmd_responder #(
    .NUM_CH(4),
    .TIMEOUT_CLKS(20)
  ) dut (
    .i_Clock(clk),
    .i_Reset_n(rst_n),
    .i_Rx_DV(rx_dv),
    .i_Rx_Byte(rx_byte),
    .i_Ch_Data(ch_data),
    .i_Tx_Active(tx_active),
    .i_Tx_Done(tx_done),
    .o_Tx_DV(tx_dv),
    .o_Tx_Byte(tx_byte),
    .o_Led(led),
    .o_Busy(busy),
    .o_Drop_Count(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response the host should see for one request, from the command table.
  function automatic logic [15:0] resp(input logic [7:0] c, input logic [7:0] a,
                                       input logic [31:0] ch, input logic [7:0] drop);
    logic [31:0] sh;
    case (c)
      8'h01: begin
        if (a < 8'd4) begin
          sh = ch >> (8 * int'(a));
          return {8'h01, sh[7:0]};
        end
        return {8'hFE, a};
      end
      8'h02:   return {8'h02, 5'b0, a[2:0]};
      8'h03:   return {8'h03, drop};
      default: return {8'hFF, c};
    endcase
  endfunction

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
      holding = 1'b0;
    end else begin
      if (tx_dv) begin
        dv_count++;
        chk("dv_back_to_back", {31'b0, prev_dv}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_dv", 32'd1, 32'd0);
        end else begin
          chk("tx_byte", tx_byte, exp_q.pop_front());
        end
        hold_byte = tx_byte;
        holding   = 1'b1;
      end else if (holding) begin
        chk("tx_byte_hold", tx_byte, hold_byte);
        if (tx_done) holding = 1'b0;
      end
      prev_dv = tx_dv;
    end
  end

  // Transmitter: answers each o_Tx_DV with i_Tx_Done tx_dly cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        repeat (tx_dly) @(posedge clk);
        #1 tx_done_m = 1'b1;
        @(posedge clk);
        #1 tx_done_m = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1 rx_dv = 1'b0;
  endtask

  task automatic inject(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hA5);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input int gap);
    logic [15:0] r;
    r = resp(c, a, ch_data, exp_drop);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
    if (c == 8'h02) exp_led = a[2:0];
    send_byte(c);
    repeat (gap) @(posedge clk);
    send_byte(a);
    chk("exec_no_dv", {31'b0, tx_dv}, 32'd0);
    @(posedge clk);
    #1;
    chk("code_latency", {31'b0, tx_dv}, 32'd1);
    chk("code_byte", tx_byte, {24'b0, r[15:8]});
    chk("led_after_exec", led, {29'b0, exp_led});
  endtask

  task automatic wait_dv(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (dv_count >= target) break;
      @(posedge clk);
      #1;
    end
    chk("dv_wait", {31'b0, dv_count >= target}, 32'd1);
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    chk("idle_after_resp", {31'b0, busy}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("drop_count", drop_cnt, {24'b0, exp_drop});
    chk("led_hold", led, {29'b0, exp_led});
  endtask

  initial begin
    int base;

    #2;
    chk("rst_tx_dv", {31'b0, tx_dv}, 32'd0);
    chk("rst_tx_byte", tx_byte, 32'd0);
    chk("rst_led", led, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_drop", drop_cnt, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Channel read with literal expectations
    base = dv_count;
    send_frame(8'h01, 8'h02, 0);
    chk("t1_code_lit", tx_byte, 32'h01);
    wait_dv(base + 2);
    chk("t1_data_lit", tx_byte, 32'h5A);
    finish_frame();

    // LED write
    send_frame(8'h02, 8'h07, 0);
    chk("t2_led_lit", led, 32'h7);
    finish_frame();

    // Out-of-range channel, last valid channel, unknown command
    send_frame(8'h01, 8'h09, 0);
    finish_frame();
    send_frame(8'h01, 8'h03, 0);
    finish_frame();
    send_frame(8'hCA, 8'h00, 0);
    finish_frame();

    // Timeout after CMD with no ARG
    base = dv_count;
    send_byte(8'h01);
    repeat (19) @(posedge clk);
    #0;
    chk("wait_arg_last_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("timeout_idle", {31'b0, busy}, 32'd0);
    chk("timeout_drop_lit", drop_cnt, 32'h01);
    chk("timeout_no_dv", dv_count, base);
    exp_drop = 8'h01;
    send_frame(8'h03, 8'h00, 0);
    finish_frame();

    // ARG arriving in the final cycle before timeout is accepted
    send_frame(8'h02, 8'h05, 18);
    finish_frame();

    // Stray i_Tx_Done while idle is ignored
    base = dv_count;
    @(posedge clk);
    #1 done_force = 1'b1;
    @(posedge clk);
    #1 done_force = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_done_busy", {31'b0, busy}, 32'd0);
    chk("idle_done_no_dv", dv_count, base);

    // Three bytes arriving during WAIT_CODE are dropped
    tx_dly = 10;
    send_frame(8'h03, 8'h00, 0);
    inject(3);
    exp_drop = exp_drop + 8'd3;
    finish_frame();

    // Drop counter saturation
    tx_dly = 700;
    send_frame(8'h03, 8'h00, 0);
    inject(300);
    exp_drop = 8'hFF;
    finish_frame();
    tx_dly = 4;
    repeat (10) @(posedge clk);
    send_frame(8'h03, 8'h00, 0);
    finish_frame();
    chk("sat_drop_lit", drop_cnt, 32'hFF);

    // Reset during WAIT_DATA
    base = dv_count;
    send_frame(8'h01, 8'h00, 0);
    wait_dv(base + 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_dv", {31'b0, tx_dv}, 32'd0);
    chk("mid_rst_tx_byte", tx_byte, 32'd0);
    chk("mid_rst_led", led, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_drop", drop_cnt, 32'd0);
    exp_drop = '0;
    exp_led  = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = dv_count;
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_no_dv", dv_count, base);
    send_frame(8'h01, 8'h01, 0);
    finish_frame();
    send_frame(8'h03, 8'h00, 0);
    finish_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Command/response engine on the FPGA side of the host UART link.
- Consumes bytes from uart_rx (i_Rx_DV/i_Rx_Byte), parses 2-byte request frames {CMD, ARG} and executes them.
- Returns a 2-byte response {CODE, DATA} through uart_tx (o_Tx_DV/o_Tx_Byte, i_Tx_Done).
- Sits between the UART pair and the sensor/LED logic in the top level.

Parameters:
- NUM_CH, 4, number of 8-bit readable channels on i_Ch_Data; legal 1..256.
- TIMEOUT_CLKS, 50000000, maximum clocks between CMD and ARG bytes before the partial frame is discarded; minimum 2.

Ports:
- i_Clock  input  1  system clock; all logic on rising edge.
- i_Reset_n  input  1  asynchronous active-low reset.
- i_Rx_DV  input  1  one-cycle strobe: i_Rx_Byte valid.
- i_Rx_Byte  input  8  received byte.
- i_Ch_Data  input  8*NUM_CH  channel k occupies bits [8k+7:8k].
- i_Tx_Active  input  1  transmitter busy; informational only.
- i_Tx_Done  input  1  one-cycle strobe: current byte fully sent.
- o_Tx_DV  output  1  one-cycle request to send o_Tx_Byte.
- o_Tx_Byte  output  8  byte to transmit; held stable from o_Tx_DV until the matching i_Tx_Done.
- o_Led  output  3  LED register.
- o_Busy  output  1  high in every state except IDLE.
- o_Drop_Count  output  8  saturating count of discarded bytes and frames.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_Tx_DV=0, o_Tx_Byte=0, o_Led=0, o_Busy=0, o_Drop_Count=0; timeout counter=0. Reset mid-frame or mid-response abandons the operation; no further o_Tx_DV.
- States: IDLE, WAIT_ARG, EXEC, SEND_CODE, WAIT_CODE, SEND_DATA, WAIT_DATA.
- IDLE:
  - i_Rx_DV: latch CMD, clear timeout counter, go to WAIT_ARG.
- WAIT_ARG:
  - i_Rx_DV: latch ARG, go to EXEC.
  - Otherwise the counter increments. When it reaches TIMEOUT_CLKS-1 without a byte: return to IDLE, o_Drop_Count+1, send no response.
  - A byte arriving in the same cycle as the timeout is accepted as ARG.
- EXEC (1 cycle) computes {CODE, DATA}:
  - CMD 0x01 read, ARG<NUM_CH: CODE=0x01, DATA=channel ARG.
  - CMD 0x01 read, ARG>=NUM_CH: CODE=0xFE, DATA=ARG.
  - CMD 0x02 LED: o_Led<=ARG[2:0] (visible the cycle after EXEC); CODE=0x02, DATA={5'b0,ARG[2:0]}.
  - CMD 0x03 status: CODE=0x03, DATA=o_Drop_Count value at EXEC.
  - Any other CMD: CODE=0xFF, DATA=CMD.
  - Channel data is sampled in EXEC only.
- SEND_CODE (1 cycle): o_Tx_DV=1, o_Tx_Byte=CODE, then WAIT_CODE.
- Latency: ARG strobe in cycle N -> EXEC in N+1 -> o_Tx_DV high in N+2.
- WAIT_CODE: on i_Tx_Done go to SEND_DATA.
- SEND_DATA (1 cycle): o_Tx_DV=1, o_Tx_Byte=DATA, then WAIT_DATA.
- WAIT_DATA: on i_Tx_Done go to IDLE. A byte arriving in the cycle the state returns to IDLE is dropped; acceptance starts the cycle after.
- i_Tx_Done in any state other than WAIT_CODE/WAIT_DATA is ignored.
- o_Tx_DV is never high in two consecutive cycles.
- Drop counting: i_Rx_DV in EXEC, SEND_*, or WAIT_* increments o_Drop_Count and the byte is discarded.
- o_Drop_Count saturates at 0xFF. A timeout and a dropped byte never coincide, because the timeout fires only in WAIT_ARG.
- No wait on i_Tx_Done timeout; the transmitter is trusted to complete.

Test Plan:
- Reset, then Rx 0x01,0x02 with i_Ch_Data ch2=0x5A -> o_Tx_DV 2 cycles after second strobe with 0x01; after Done, 0x5A; o_Busy low after second Done.
- Rx 0x02,0x07 -> o_Led=3'b111 one cycle after EXEC; response 0x02,0x07.
- Rx 0x01,0x09 (NUM_CH=4) -> 0xFE,0x09; Rx 0xCA,0x00 -> 0xFF,0xCA.
- Rx 0x01 then no byte for TIMEOUT_CLKS (set 20) -> no o_Tx_DV, o_Drop_Count=1; then 0x03,0x00 -> 0x03,0x01.
- Inject 3 Rx strobes during WAIT_CODE -> o_Drop_Count+3, response unchanged; 300 drops -> count holds 0xFF.
- Deassert i_Reset_n during WAIT_DATA -> all outputs 0 immediately; no o_Tx_DV after release until a new full frame.
